// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronise and filter the pins, frame and check each
// 11-bit word, fold E0/F0 prefixes into flags and queue codes in a FWFT FIFO.
module ps2_scan_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ps2c,
   input  logic                        ps2d,
   output logic [7:0]                  code,
   output logic                        extended,
   output logic                        released,   // break flag; `release` is a reserved word
   output logic                        valid,
   input  logic                        ready,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        overflow,
   input  logic                        clr_ovf,
   output logic                        parity_err,
   output logic                        frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [7:0]    PFX_EXT   = 8'hE0;
   localparam logic [7:0]    PFX_BRK   = 8'hF0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // ---------------- input synchronisers and clock filter ----------------
   logic [1:0] c_sync, d_sync;
   logic [7:0] filt_cnt;
   logic       filt_clk, filt_prev;
   logic       fall, data_bit;

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_sync    <= 2'b11;
         d_sync    <= 2'b11;
         filt_cnt  <= '0;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
      end else begin
         c_sync    <= {c_sync[0], ps2c};
         d_sync    <= {d_sync[0], ps2d};
         filt_prev <= filt_clk;
         if (c_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= c_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 8'd1;
         end
      end
   end

   assign fall     = filt_prev & ~filt_clk;
   assign data_bit = d_sync[1];

   // ---------------- frame FSM ----------------
   state_t        state, state_nx;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg, byte_r;
   logic          par_bit;
   logic [TW-1:0] tmo;
   logic          tmo_hit;
   logic          good_nx, perr_nx, ferr_nx, frame_ok;

   assign tmo_hit = (tmo == TMO_LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      good_nx  = 1'b0;
      perr_nx  = 1'b0;
      ferr_nx  = 1'b0;
      if (state != IDLE && tmo_hit) begin
         state_nx = IDLE;
         ferr_nx  = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE:    if (!data_bit) state_nx = DATA;
            DATA:    if (bit_idx == 3'd7) state_nx = PARITY;
            PARITY:  state_nx = STOP;
            STOP: begin
               state_nx = IDLE;
               if (!data_bit)                   ferr_nx = 1'b1;
               else if (^{shreg, par_bit} == 1'b0) perr_nx = 1'b1;
               else                             good_nx = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_idx    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tmo        <= '0;
         byte_r     <= '0;
         frame_ok   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_ok   <= good_nx;
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         if (good_nx) byte_r <= shreg;
         if (state == IDLE || fall) tmo <= '0;
         else                       tmo <= tmo + 1'b1;
         if (fall) begin
            case (state)
               IDLE:   bit_idx <= '0;
               DATA: begin
                  shreg   <= {data_bit, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
               PARITY: par_bit <= data_bit;
               default: ;
            endcase
         end
      end
   end

   // ---------------- prefix folding ----------------
   logic ext_p, brk_p, push;

   assign push = frame_ok && (byte_r != PFX_EXT) && (byte_r != PFX_BRK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_p <= 1'b0;
         brk_p <= 1'b0;
      end else if (parity_err || frame_err || push) begin
         ext_p <= 1'b0;
         brk_p <= 1'b0;
      end else if (frame_ok) begin
         if (byte_r == PFX_EXT) ext_p <= 1'b1;
         else                   brk_p <= 1'b1;
      end
   end

   // ---------------- first-word-fall-through FIFO ----------------
   logic [9:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [9:0]  head;
   logic        full, pop, wr_en, ovf_evt;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == FULL_CNT);
   assign valid   = (count != '0);
   assign pop     = valid & ready;
   assign wr_en   = push & (~full | pop);
   assign ovf_evt = push & full & ~pop;

   // NOTE: the storage array carries no reset; the pointers alone define
   // which entries are meaningful, and empty output is forced to zero below.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {ext_p, brk_p, byte_r};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)        wr_ptr <= wr_ptr + 1'b1;
         if (pop)          rd_ptr <= rd_ptr + 1'b1;
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   assign head     = valid ? mem[rd_ptr[AW-1:0]] : 10'd0;
   assign extended = head[9];
   assign released = head[8];
   assign code     = head[7:0];

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: directed scenarios plus random
// frames compared against a queue-based model of the decoded key stream.
module tb_ps2_scan_receiver;

   localparam int FL    = 4;
   localparam int TMO   = 400;
   localparam int DEPTH = 4;
   localparam int HALF  = 15;

   logic       clk = 1'b0;
   logic       reset, ps2c, ps2d, ready, clr_ovf;
   logic [7:0] code;
   logic       extended, released, valid, overflow, parity_err, frame_err;
   logic [2:0] count;

   ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
      .code(code), .extended(extended), .released(released), .valid(valid),
      .ready(ready), .count(count), .overflow(overflow), .clr_ovf(clr_ovf),
      .parity_err(parity_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int perr_seen = 0, ferr_seen = 0;
   int exp_perr = 0, exp_ferr = 0;

   logic [9:0] q[$];
   bit m_ext, m_brk, m_ovf;

   always @(posedge clk) begin
      if (parity_err === 1'b1) perr_seen++;
      if (frame_err === 1'b1)  ferr_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: what a keyboard host should conclude from one received frame.
   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      if (bad_stop) begin
         exp_ferr++; m_ext = 0; m_brk = 0;
      end else if (bad_par) begin
         exp_perr++; m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
         else                  m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk) ps2d = b;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(~bad_stop);
      ps2d = 1'b1;
      repeat (40) @(negedge clk);
      model_frame(b, bad_par, bad_stop);
   endtask

   task automatic check_state(input string tag);
      logic [9:0] eh;
      logic [2:0] ec;
      eh = (q.size() != 0) ? q[0] : 10'd0;
      ec = 3'(q.size());
      check({tag, ".valid"}, valid, q.size() != 0);
      check({tag, ".count"}, count, ec);
      check({tag, ".head"}, {extended, released, code}, eh);
      check({tag, ".overflow"}, overflow, m_ovf);
      check({tag, ".parity_err_n"}, perr_seen, exp_perr);
      check({tag, ".frame_err_n"}, ferr_seen, exp_ferr);
   endtask

   task automatic pop_one(input string tag);
      logic [9:0] eh;
      if (q.size() != 0) begin
         eh = q[0];
         check({tag, ".pop_head"}, {extended, released, code}, eh);
      end
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic clear_ovf();
      @(negedge clk) clr_ovf = 1'b1;
      @(negedge clk) clr_ovf = 1'b0;
      m_ovf = 0;
   endtask

   initial begin
      reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; ready = 1'b0; clr_ovf = 1'b0;
      repeat (5) @(negedge clk);
      check_state("reset");
      check("reset.perr_out", parity_err, 1'b0);
      check("reset.ferr_out", frame_err, 1'b0);
      reset = 1'b1;
      repeat (10) @(negedge clk);

      send_frame(8'h1C, 0, 0);
      check_state("good1c");
      pop_one("good1c");
      check_state("good1c_popped");

      send_frame(8'hE0, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h74, 0, 0);
      check_state("e0f074");
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
      check_state("f01c");
      pop_one("f01c_a");
      pop_one("f01c_b");
      check_state("f01c_drained");

      send_frame(8'h1C, 1, 0);
      check_state("bad_parity");
      send_frame(8'hF0, 0, 0);
      send_frame(8'h55, 0, 1);
      send_frame(8'h1C, 0, 0);
      check_state("bad_stop");
      pop_one("bad_stop");

      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (TMO + 60) @(negedge clk);
      exp_ferr++; m_ext = 0; m_brk = 0;
      check_state("timeout");
      send_frame(8'h29, 0, 0);
      check_state("after_timeout");
      pop_one("after_timeout");

      send_frame(8'h15, 0, 0);
      send_frame(8'h1D, 0, 0);
      send_frame(8'h24, 0, 0);
      send_frame(8'h2D, 0, 0);
      send_frame(8'h2C, 0, 0);
      check_state("overflow");
      for (int i = 0; i < 4; i++) pop_one("ovf_drain");
      check_state("ovf_drained");
      clear_ovf();
      check_state("ovf_cleared");

      send_frame(8'h33, 0, 0);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      @(negedge clk) reset = 1'b0;
      q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
      repeat (3) @(negedge clk);
      check_state("mid_reset");
      reset = 1'b1;
      repeat (40) @(negedge clk);
      send_frame(8'h1C, 0, 0);
      check_state("after_reset");
      pop_one("after_reset");

      for (int n = 0; n < 40; n++) begin
         int k;
         logic [7:0] b;
         k = $urandom_range(0, 19);
         b = 8'($urandom_range(0, 255));
         case (k)
            0, 1:    send_frame(b, 1, 0);
            2, 3:    send_frame(b, 0, 1);
            4, 5, 6: send_frame(8'hE0, 0, 0);
            7, 8, 9: send_frame(8'hF0, 0, 0);
            default: send_frame(b, 0, 0);
         endcase
         check_state("rand");
         if ($urandom_range(0, 2) == 0) pop_one("rand");
         if ($urandom_range(0, 7) == 0) clear_ovf();
      end
      while (q.size() != 0) pop_one("final_drain");
      check_state("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
